// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table and bit order.
package seg_pkg;

    // Bit positions inside the 7-bit active-high a-g vector.
    localparam int unsigned SEG7_BIT_A = 6;
    localparam int unsigned SEG7_BIT_G = 0;

    // Bit positions inside the 8-bit {a,b,c,d,e,f,g,dp} output byte.
    localparam int unsigned SEG_BIT_A  = 7;
    localparam int unsigned SEG_BIT_DP = 0;

    // All segments dark on the active-low output.
    localparam logic [7:0] SEG_OFF_N = 8'hFF;

    // Glyphs for codes 0-9 and A,b,C,d,E,F as {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex code to seven-segment glyph decoder, active-high {a..g}.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure table lookup; no state.
    always_comb begin
        seg = SEG_LUT[code];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-aligned shadow
// registers, leading-zero blanking and per-digit blink.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned CLK_HZ      = 48_000_000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   i_val,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blink,
    input  logic                  i_lz_blank,
    input  logic                  i_load,
    output logic                  o_frame,
    output logic [DIGITS-1:0]     o_index_n,
    output logic [7:0]            o_seg_n
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [CNT_W-1:0]    cnt_q;
    logic                tick;
    logic                wrap;
    logic                started_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [BLK_W-1:0]    blink_cnt_q;
    logic                phase_q;

    logic [4*DIGITS-1:0] stg_val_q;
    logic [DIGITS-1:0]   stg_dp_q;
    logic [DIGITS-1:0]   stg_blink_q;
    logic                stg_lz_q;
    logic                pend_q;
    logic                pend_d;

    logic [4*DIGITS-1:0] act_val_q;
    logic [4*DIGITS-1:0] act_val_d;
    logic [DIGITS-1:0]   act_dp_q;
    logic [DIGITS-1:0]   act_dp_d;
    logic [DIGITS-1:0]   act_blink_q;
    logic [DIGITS-1:0]   act_blink_d;
    logic                act_lz_q;
    logic                act_lz_d;

    logic [DIGITS-1:0]   lz_mask;
    logic                lz_seen;
    logic [3:0]          sel_code;
    logic                sel_dp;
    logic                sel_blink;
    logic                sel_blank;
    logic [6:0]          sel_seg7;
    logic [7:0]          seg_on;

    logic [DIGITS-1:0]   index_n_q;
    logic [7:0]          seg_n_q;
    logic                frame_q;

    // Tick and pointer decode. The first tick after reset is treated as a
    // wrap so that it selects digit 0 and starts a frame.
    always_comb begin
        tick    = (cnt_q == CNT_W'(DIV - 1));
        wrap    = tick && (!started_q || (ptr_q == PTR_W'(DIGITS - 1)));
        ptr_nxt = wrap ? '0 : ptr_q + PTR_W'(1);
    end

    // Tick divider, scan pointer and blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            started_q   <= 1'b0;
            ptr_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                started_q <= 1'b1;
                ptr_q     <= ptr_nxt;
                if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLK_W'(1);
                end
            end
        end
    end

    // Active set only changes on a frame boundary, so a frame never tears.
    always_comb begin
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        act_blink_d = act_blink_q;
        act_lz_d    = act_lz_q;
        pend_d      = pend_q;
        if (wrap && i_load) begin
            act_val_d   = i_val;
            act_dp_d    = i_dp;
            act_blink_d = i_blink;
            act_lz_d    = i_lz_blank;
            pend_d      = 1'b0;
        end else if (wrap && pend_q) begin
            act_val_d   = stg_val_q;
            act_dp_d    = stg_dp_q;
            act_blink_d = stg_blink_q;
            act_lz_d    = stg_lz_q;
            pend_d      = 1'b0;
        end else if (i_load) begin
            pend_d = 1'b1;
        end
    end

    // Staging and active display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_val_q   <= '0;
            stg_dp_q    <= '0;
            stg_blink_q <= '0;
            stg_lz_q    <= 1'b0;
            pend_q      <= 1'b0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            act_blink_q <= '0;
            act_lz_q    <= 1'b0;
        end else begin
            if (i_load && !wrap) begin
                stg_val_q   <= i_val;
                stg_dp_q    <= i_dp;
                stg_blink_q <= i_blink;
                stg_lz_q    <= i_lz_blank;
            end
            pend_q      <= pend_d;
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            act_blink_q <= act_blink_d;
            act_lz_q    <= act_lz_d;
        end
    end

    // Select the digit about to be shown; decode from the next-state active
    // set so a load on the wrapping tick is visible on digit 0 immediately.
    always_comb begin
        lz_mask   = '0;
        lz_seen   = 1'b0;
        sel_code  = 4'd0;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_blank = 1'b0;
        // Digit k is a leading zero when it and every digit above it are zero.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_seen    = lz_seen | (act_val_d[4*k +: 4] != 4'd0);
            lz_mask[k] = ~lz_seen;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (ptr_nxt == PTR_W'(k)) begin
                sel_code  = act_val_d[4*k +: 4];
                sel_dp    = act_dp_d[k];
                sel_blink = act_blink_d[k];
                sel_blank = act_lz_d & lz_mask[k];
            end
        end
        seg_on = {sel_seg7 & ~{7{sel_blank}}, sel_dp};
        if (sel_blink && !phase_q) begin
            seg_on = '0;
        end
    end

    seg7_decode u_decode (
        .code (sel_code),
        .seg  (sel_seg7)
    );

    // Registered drivers: new digit appears the cycle after its tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_n_q <= '1;
            seg_n_q   <= SEG_OFF_N;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= wrap;
            if (tick) begin
                index_n_q <= ~(DIGITS'(1) << ptr_nxt);
                seg_n_q   <= ~seg_on;
            end
        end
    end

    assign o_index_n = index_n_q;
    assign o_seg_n   = seg_n_q;
    assign o_frame   = frame_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter CLK_HZ, default 48_000_000, clk frequency in Hz.
REQ-003 Parameter SCAN_HZ, default 1000, per-digit step rate in Hz; DIV = CLK_HZ/SCAN_HZ, DIV >= 2.
REQ-004 Parameter BLINK_TICKS, default 250, scan ticks per blink half-period, value >= 1.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 i_val  in  4*DIGITS  digit codes, digit k at [4k+3:4k], digit 0 least significant.
REQ-008 i_dp  in  DIGITS  decimal-point enable per digit.
REQ-009 i_blink  in  DIGITS  blink enable per digit.
REQ-010 i_lz_blank  in  1  leading-zero blanking enable.
REQ-011 i_load  in  1  one-cycle strobe, captures i_val/i_dp/i_blink/i_lz_blank.
REQ-012 o_frame  out  1  one-cycle pulse at each frame start.
REQ-013 o_index_n  out  DIGITS  digit enables, active-low, one-hot-low.
REQ-014 o_seg_n  out  8  segments {a,b,c,d,e,f,g,dp} at [7:0], active-low.

Function
REQ-015 Tick counter SHALL count 0..DIV-1 and wrap; tick is high for the one cycle the counter equals DIV-1.
REQ-016 Scan pointer SHALL advance by 1 on each tick, wrapping from DIGITS-1 to 0; DIGITS=1 holds at 0.
REQ-017 o_frame SHALL be high in the cycle after a tick that wraps the pointer to 0.
REQ-018 i_load SHALL write a staging copy and set a pending flag; a later load before transfer overwrites staging.
REQ-019 On a wrapping tick with pending set, staging SHALL copy to the active set and pending clear; display never tears mid-frame.
REQ-020 i_load coincident with a wrapping tick SHALL write the new inputs directly to the active set and leave pending clear.
REQ-021 Codes 0-9 SHALL decode to standard digits; 10-15 to A,b,C,d,E,F.
REQ-022 With active lz_blank set, every digit above the highest nonzero digit SHALL be blanked (segments a-g off); digit 0 is never blanked; dp unaffected.
REQ-023 Blink phase SHALL toggle every BLINK_TICKS ticks; while phase is 0, digits with active blink bit have all 8 segments off.
REQ-024 o_index_n and o_seg_n SHALL be registered, updating the cycle after each tick for the newly selected digit; latency tick->output = 1 clk.
REQ-025 Exactly one o_index_n bit SHALL be low at all times after the first tick.

Reset
REQ-026 rst SHALL immediately force o_index_n all ones, o_seg_n all ones, o_frame 0.
REQ-027 rst SHALL clear tick counter, scan pointer, staging, active set and pending; blink phase resets to 1 (visible).
REQ-028 rst asserted mid-frame or mid-blink SHALL discard all state; the first tick after release selects digit 0.

Structure
REQ-029 Shared package seg_pkg SHALL hold the 16-entry segment pattern constants and segment bit-order constants.
REQ-030 Decode SHALL be a sub-module seg7_decode (4-bit code in, 7-bit a-g out, active-high); scan/shadow/blink logic stays in seg_scan_ctrl.

Verification (DIGITS=4, CLK_HZ=1000, SCAN_HZ=100, DIV=10, BLINK_TICKS=4)
REQ-031 Reset release, no load -> o_index_n 1111 until first tick; then 1110,1101,1011,0111 every 10 clk; o_seg_n 0x03 ("0", a-f on).
REQ-032 Load i_val=0x1234, i_dp=0010 mid-frame -> old value held until wrap; next frame digit0 "4", digit1 "3" with dp (o_seg_n 0x0C), digit3 "1" (0x9F).
REQ-033 Load i_val=0x0070, i_lz_blank=1 -> digits 3,2 o_seg_n 0xFF, digit1 "7" (0x1F), digit0 "0" (0x03).
REQ-034 i_blink=0001 -> digit0 visible 4 ticks, 0xFF 4 ticks, repeating; other digits steady.
REQ-035 i_load on wrapping tick with i_val=0xABCD -> same frame shows "d","C","b","A"; two loads 0x1111 then 0x2222 inside one frame -> only 0x2222 displayed.
REQ-036 rst pulse during digit2 -> outputs all ones within the same cycle; after release scan restarts at digit0, active value 0000.
